guess_tx: RTL

- Transmit side of the interboard guess exchange.
- When the local player confirms a guess during GAME_P1_GUESS, the block validates the two-digit BCD number and converts it to a 0-based cell index (0..24).
- It then delivers the index to the opposite board over a 4-phase req/ack handshake with timeout and bounded retry.
- It reports done/fail to the game controller; the opposite board's receiver marks its own circle map from the delivered index.

---
 rtl/bingo_pkg.sv | 48 ++++
 rtl/guess_tx_if.sv | 18 +
 rtl/sync_2ff.sv | 28 ++
 rtl/guess_tx.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/bingo_pkg.sv
// -----------------------------------------------------------------------------
// bingo_pkg
//   Definitions shared by the interboard guess transmitter and receiver:
//   game FSM state codes, board geometry, fail_code encodings, the transmitter
//   state type and the BCD helpers used to validate and convert guesses.
// -----------------------------------------------------------------------------
package bingo_pkg;

    // Game controller state codes seen on cur_game_state
    localparam logic [3:0] GAME_P1_GUESS          = 4'd4;
    localparam logic [3:0] GAME_WAIT_UPDATE_GUESS = 4'd10;

    // Board geometry: 25 cells, 0-based index fits in 5 bits
    localparam int NUM_CELLS = 25;
    localparam int CELL_W    = 5;

    typedef enum logic [1:0] {
        FAIL_NONE      = 2'd0,
        FAIL_INVALID   = 2'd1,
        FAIL_NO_ACK    = 2'd2,
        FAIL_ACK_STUCK = 2'd3
    } fail_code_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_LOAD,
        TX_REQ,
        TX_BACKOFF,
        TX_RELEASE,
        TX_DONE,
        TX_FAIL
    } tx_state_e;

    // Both digits must be decimal for the guess to mean anything
    function automatic logic bcd_digits_ok(input logic [7:0] bcd);
        return (bcd[7:4] <= 4'd9) && (bcd[3:0] <= 4'd9);
    endfunction

    // 10*tens + units, 7 bits wide. Only meaningful when both digits are <= 9.
    function automatic logic [6:0] bcd_to_bin(input logic [7:0] bcd);
        logic [6:0] tens;
        logic [6:0] units;
        tens  = {3'b000, bcd[7:4]};
        units = {3'b000, bcd[3:0]};
        return 7'(tens * 7'd10) + units;
    endfunction

endpackage

// File: rtl/guess_tx_if.sv
// -----------------------------------------------------------------------------
// guess_tx_if
//   Interboard guess link: 4-phase req/ack handshake carrying a cell index.
//   master : the transmitting board (drives tx_req / tx_data)
//   slave  : the receiving board (drives tx_ack)
//   tx_ack is asynchronous to the master's clock.
// -----------------------------------------------------------------------------
interface guess_tx_if;
    import bingo_pkg::*;

    logic              tx_req;
    logic [CELL_W-1:0] tx_data;
    logic              tx_ack;

    modport master (output tx_req, output tx_data, input tx_ack);
    modport slave  (input tx_req, input tx_data, output tx_ack);

endinterface

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   Generic 1-bit two-flop synchronizer, asynchronous active-low reset to 0.
//   clk  : destination clock
//   rst  : asynchronous reset, active low
//   d    : asynchronous input
//   q    : synchronized output (two destination clocks of latency)
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/guess_tx.sv
// -----------------------------------------------------------------------------
// guess_tx
//   Transmit side of the interboard guess exchange. On a confirmed guess in
//   GAME_P1_GUESS the BCD number is validated, converted to a 0-based cell
//   index and delivered over a 4-phase req/ack handshake with per-phase
//   timeout and bounded retry.
//
//   clk, rst            : clock, asynchronous active-low reset
//   interboard_rst      : synchronous abort from the link (no done/fail pulse)
//   cur_game_state      : game FSM state code
//   send_guess          : one-cycle send request
//   guess_BCD           : [7:4] tens, [3:0] units
//   busy                : high from acceptance until back in IDLE
//   send_done/send_fail : one-cycle result pulses
//   fail_code           : reason of the last failure, held until next accept
//   link                : handshake (tx_req, tx_data out; tx_ack in, async)
// -----------------------------------------------------------------------------
module guess_tx
    import bingo_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int BACKOFF_CYCLES = 1000,
    parameter int MAX_RETRY      = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              interboard_rst,
    input  logic [3:0]        cur_game_state,
    input  logic              send_guess,
    input  logic [7:0]        guess_BCD,
    output logic              busy,
    output logic              send_done,
    output logic              send_fail,
    output logic [1:0]        fail_code,
    guess_tx_if.master        link
);

    // One counter serves both the handshake timeout and the backoff wait
    localparam int CNT_MAX = (TIMEOUT_CYCLES > BACKOFF_CYCLES) ? TIMEOUT_CYCLES : BACKOFF_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam int RTRY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  BO_LAST   = CNT_W'(BACKOFF_CYCLES - 1);
    localparam logic [RTRY_W-1:0] RETRY_LIM = RTRY_W'(MAX_RETRY);

    tx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [RTRY_W-1:0] retry_q, retry_d;
    fail_code_e        fail_code_q, fail_code_d;
    logic [CELL_W-1:0] tx_data_q;
    logic              tx_req_q, busy_q, done_q, fail_q;

    logic              ack_s;
    logic              accept, num_ok, load_en;
    logic              to_hit, bo_hit, cnt_run;
    logic [6:0]        num;

    // Raw tx_ack is asynchronous; nothing below looks at it directly
    sync_2ff u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (link.tx_ack),
        .q   (ack_s)
    );

    assign accept = send_guess && (cur_game_state == GAME_P1_GUESS);
    assign num    = bcd_to_bin(guess_BCD);
    assign num_ok = bcd_digits_ok(guess_BCD) && (num >= 7'd1) && (num <= 7'(NUM_CELLS));

    // >= rather than == so a count held past the limit (BACKOFF waiting for
    // ack_s to drop) still reads as expired
    assign to_hit  = (cnt_q >= TO_LAST);
    assign bo_hit  = (cnt_q >= BO_LAST);
    assign cnt_run = (state_q == TX_REQ) || (state_q == TX_BACKOFF) || (state_q == TX_RELEASE);

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d     = state_q;
        retry_d     = retry_q;
        fail_code_d = fail_code_q;
        load_en     = 1'b0;

        unique case (state_q)
            TX_IDLE: begin
                if (accept) begin
                    if (num_ok) begin
                        // tx_data is captured on the accepting edge so it is
                        // valid for the whole LOAD cycle, one cycle ahead of tx_req
                        state_d     = TX_LOAD;
                        load_en     = 1'b1;
                        fail_code_d = FAIL_NONE;
                    end else begin
                        state_d     = TX_FAIL;
                        fail_code_d = FAIL_INVALID;
                    end
                end
            end
            TX_LOAD: begin
                state_d     = TX_REQ;
                retry_d     = '0;
                fail_code_d = FAIL_NONE;
            end
            TX_REQ: begin
                if (ack_s) begin
                    state_d = TX_RELEASE;
                end else if (to_hit) begin
                    if (retry_q == RETRY_LIM) begin
                        state_d     = TX_FAIL;
                        fail_code_d = FAIL_NO_ACK;
                    end else begin
                        state_d = TX_BACKOFF;
                        retry_d = retry_q + 1'b1;
                    end
                end
            end
            TX_BACKOFF: begin
                // A late ack from the previous attempt must clear before
                // re-requesting, otherwise it would be taken as this attempt's ack
                if (bo_hit && !ack_s) begin
                    state_d = TX_REQ;
                end
            end
            TX_RELEASE: begin
                if (!ack_s) begin
                    state_d = TX_DONE;
                end else if (to_hit) begin
                    state_d     = TX_FAIL;
                    fail_code_d = FAIL_ACK_STUCK;
                end
            end
            TX_DONE: state_d = TX_IDLE;
            TX_FAIL: state_d = TX_IDLE;
            default: state_d = TX_IDLE;
        endcase

        // Link abort wins over everything; fail_code and tx_data are left alone
        if (interboard_rst) begin
            state_d     = TX_IDLE;
            retry_d     = '0;
            fail_code_d = fail_code_q;
            load_en     = 1'b0;
        end
    end

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= TX_IDLE;
            cnt_q       <= '0;
            retry_q     <= '0;
            fail_code_q <= FAIL_NONE;
            tx_data_q   <= '0;
            tx_req_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            retry_q     <= retry_d;
            fail_code_q <= fail_code_d;

            // Fresh count on every state change; saturates at all-ones
            if (interboard_rst || (state_d != state_q) || !cnt_run) begin
                cnt_q <= '0;
            end else if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (load_en) begin
                tx_data_q <= CELL_W'(num - 7'd1);
            end

            // Outputs registered from next state so they line up with state_q
            tx_req_q <= (state_d == TX_REQ);
            busy_q   <= (state_d != TX_IDLE);
            done_q   <= (state_d == TX_DONE);
            fail_q   <= (state_d == TX_FAIL);
        end
    end

    assign link.tx_req  = tx_req_q;
    assign link.tx_data = tx_data_q;
    assign busy         = busy_q;
    assign send_done    = done_q;
    assign send_fail    = fail_q;
    assign fail_code    = fail_code_q;

endmodule
